dmem_ctrl: RTL and testbench

//  Parametrised data-memory controller for the DP datapath: replaces the fixed 8-bit-address, 32-bit

---
 rtl/dp_pkg.sv | 14 +
 rtl/dmem_array.sv | 39 +++
 rtl/dmem_ctrl.sv | 110 +++++++++++
 tb/tb_dmem_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// Shared definitions for the DP datapath memory path.
package dp_pkg;

   // rw encoding inherited from the original DP memory port
   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Storage for the data memory: DEPTH words, per-byte write, registered read port.
module dmem_array #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   parameter int IDX_W  = 8
) (
   input  logic                  clock,
   input  logic                  we,
   input  logic                  re,
   input  logic [IDX_W-1:0]      addr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W/8-1:0]   be,
   output logic [DATA_W-1:0]     rdata
);

   localparam int NB = DATA_W / 8;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q, rdata_d;

   // read register only moves on a read strobe so the response stays stable while held
   always_comb begin
      rdata_d = rdata_q;
      if (re) rdata_d = mem_q[addr];
   end

   // byte-masked write and read register update; contents are deliberately not reset
   always_ff @(posedge clock) begin
      if (we) begin
         for (int i = 0; i < NB; i++) begin
            if (be[i]) mem_q[addr][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
      rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: valid/ready request and response around dmem_array,
// with configurable latency, byte enables and an out-of-range error flag.
//
//  state | meaning
//  IDLE  | ready for a request; array is accessed on the accept edge
//  WAIT  | counting down the remaining access latency
//  RESP  | response presented, held until resp_ready
module dmem_ctrl
   import dp_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 8,
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_rw,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [DATA_W/8-1:0]   req_be,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_W-1:0]     resp_rdata,
   output logic                  resp_err
);

   localparam int CNT_W = $clog2(LATENCY + 1);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   dmem_state_t       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              rw_q, rw_d;
   logic              err_q, err_d;

   logic              accept;
   logic              in_range;
   logic              arr_we, arr_re;
   logic [DATA_W-1:0] arr_rdata;

   // one extra bit so DEPTH == 2**ADDR_W never reports an error
   assign in_range  = {1'b0, req_addr} < (ADDR_W+1)'(DEPTH);
   assign req_ready = (state_q == IDLE) && !reset;
   assign accept    = req_valid && req_ready;
   assign arr_we    = accept && (req_rw == RW_WRITE) && in_range;
   assign arr_re    = accept && (req_rw == RW_READ) && in_range;

   dmem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clock (clock),
      .we    (arr_we),
      .re    (arr_re),
      .addr  (req_addr[IDX_W-1:0]),
      .wdata (req_wdata),
      .be    (req_be),
      .rdata (arr_rdata)
   );

   // sequencing: accept, count down, hold response until consumed
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rw_d    = rw_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               rw_d    = req_rw;
               err_d   = !in_range;
               cnt_d   = CNT_W'(LATENCY - 1);
               state_d = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = RESP;
         end
         RESP: begin
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // reset drops any pending access; committed writes stay in the array
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rw_q    <= RW_READ;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rw_q    <= rw_d;
         err_q   <= err_d;
      end
   end

   // response fields are only meaningful while valid; read data is zero for writes and errors
   assign resp_valid = (state_q == RESP);
   assign resp_err   = resp_valid && err_q;
   assign resp_rdata = (resp_valid && (rw_q == RW_READ) && !err_q) ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [3:0]  resp_valid;
   logic [3:0]  resp_err;
   logic        req_rw;
   logic        resp_ready;
   logic [7:0]  req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic [31:0] resp_rdata [4];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   // 0: defaults (LAT 2, DEPTH 256); 1: DEPTH 128; 2: LAT 1; 3: LAT 4
   dmem_ctrl #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .LATENCY(2)) u_a (
      .clock(clock), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .resp_valid(resp_valid[0]), .resp_ready(resp_ready), .resp_rdata(resp_rdata[0]),
      .resp_err(resp_err[0]));

   dmem_ctrl #(.DATA_W(32), .ADDR_W(8), .DEPTH(128), .LATENCY(2)) u_b (
      .clock(clock), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .resp_valid(resp_valid[1]), .resp_ready(resp_ready), .resp_rdata(resp_rdata[1]),
      .resp_err(resp_err[1]));

   dmem_ctrl #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .LATENCY(1)) u_c (
      .clock(clock), .reset(reset), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
      .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .resp_valid(resp_valid[2]), .resp_ready(resp_ready), .resp_rdata(resp_rdata[2]),
      .resp_err(resp_err[2]));

   dmem_ctrl #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .LATENCY(4)) u_d (
      .clock(clock), .reset(reset), .req_valid(req_valid[3]), .req_ready(req_ready[3]),
      .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .resp_valid(resp_valid[3]), .resp_ready(resp_ready), .resp_rdata(resp_rdata[3]),
      .resp_err(resp_err[3]));

   // One complete access on instance s. lat counts cycles from the request cycle
   // to the first cycle resp_valid is seen; the response is consumed on exit.
   task automatic access(input int s, input logic rw, input logic [7:0] addr,
                         input logic [31:0] wd, input logic [3:0] be,
                         output int lat, output logic [31:0] rd, output logic er);
      int k;
      req_rw = rw; req_addr = addr; req_wdata = wd; req_be = be;
      resp_ready = 1'b1;
      req_valid[s] = 1'b1;
      k = 0;
      while (!req_ready[s] && k < 20) begin
         @(negedge clock);
         k++;
      end
      @(negedge clock);
      req_valid[s] = 1'b0;
      lat = 1;
      while (!resp_valid[s] && lat < 20) begin
         @(negedge clock);
         lat++;
      end
      rd = resp_rdata[s];
      er = resp_err[s];
      @(negedge clock);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req_valid = 4'h0; req_rw = 1'b0; req_addr = 8'h00; req_wdata = 32'h0; req_be = 4'h0;
      resp_ready = 1'b1;
      @(negedge clock);
      @(negedge clock);
      n_checks++; if (resp_valid !== 4'h0) begin n_fail++; $display("FAIL reset_resp_valid: got %h expected 0", resp_valid); end
      n_checks++; if (resp_err !== 4'h0) begin n_fail++; $display("FAIL reset_resp_err: got %h expected 0", resp_err); end
      n_checks++; if (resp_rdata[0] !== 32'h0) begin n_fail++; $display("FAIL reset_resp_rdata: got %h expected 0", resp_rdata[0]); end
      n_checks++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL reset_req_ready: got %h expected 0", req_ready); end
      reset = 1'b0;
      @(negedge clock);
      n_checks++; if (req_ready !== 4'hF) begin n_fail++; $display("FAIL release_req_ready: got %h expected f", req_ready); end
   endtask

   task automatic test_write_read();
      int lat; logic [31:0] rd; logic er;
      access(0, 1'b1, 8'hAA, 32'hDEADBEEF, 4'hF, lat, rd, er);
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL wr_latency: got %0d expected 2", lat); end
      n_checks++; if (rd !== 32'h0 || er !== 1'b0) begin n_fail++; $display("FAIL wr_ack: got rdata %h err %b expected 0/0", rd, er); end
      access(0, 1'b0, 8'hAA, 32'h0, 4'h0, lat, rd, er);
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL rd_latency: got %0d expected 2", lat); end
      n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
      n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL rd_err: got %b expected 0", er); end
   endtask

   task automatic test_byte_enable();
      int lat; logic [31:0] rd; logic er;
      access(0, 1'b1, 8'h10, 32'h12345678, 4'hF, lat, rd, er);
      access(0, 1'b1, 8'h10, 32'hFFFFFFFF, 4'b0101, lat, rd, er);
      access(0, 1'b0, 8'h10, 32'h0, 4'h0, lat, rd, er);
      n_checks++; if (rd !== 32'h12FF56FF) begin n_fail++; $display("FAIL be_merge: got %h expected 12ff56ff", rd); end
      access(0, 1'b1, 8'h10, 32'hAAAAAAAA, 4'h0, lat, rd, er);
      n_checks++; if (lat !== 2 || er !== 1'b0) begin n_fail++; $display("FAIL be0_ack: got lat %0d err %b expected 2/0", lat, er); end
      access(0, 1'b0, 8'h10, 32'h0, 4'h0, lat, rd, er);
      n_checks++; if (rd !== 32'h12FF56FF) begin n_fail++; $display("FAIL be0_noop: got %h expected 12ff56ff", rd); end
   endtask

   task automatic test_out_of_range();
      int lat; logic [31:0] rd; logic er;
      access(1, 1'b1, 8'h48, 32'h55AA55AA, 4'hF, lat, rd, er);
      access(1, 1'b0, 8'hC8, 32'h0, 4'h0, lat, rd, er);
      n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL oor_rd_err: got %b expected 1", er); end
      n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL oor_rd_data: got %h expected 0", rd); end
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL oor_latency: got %0d expected 2", lat); end
      access(1, 1'b1, 8'hC8, 32'hFFFFFFFF, 4'hF, lat, rd, er);
      n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL oor_wr_err: got %b expected 1", er); end
      access(1, 1'b0, 8'h48, 32'h0, 4'h0, lat, rd, er);
      n_checks++; if (rd !== 32'h55AA55AA || er !== 1'b0) begin n_fail++; $display("FAIL oor_alias: got %h err %b expected 55aa55aa/0", rd, er); end
   endtask

   task automatic test_back_pressure();
      int k;
      req_rw = 1'b0; req_addr = 8'hAA; req_wdata = 32'h0; req_be = 4'h0;
      resp_ready = 1'b0;
      req_valid[0] = 1'b1;
      @(negedge clock);
      req_valid[0] = 1'b0;
      k = 1;
      while (!resp_valid[0] && k < 20) begin
         @(negedge clock);
         k++;
      end
      n_checks++; if (k !== 2) begin n_fail++; $display("FAIL bp_latency: got %0d expected 2", k); end
      for (int i = 0; i < 5; i++) begin
         n_checks++; if (resp_valid[0] !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, resp_valid[0]); end
         n_checks++; if (resp_rdata[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bp_rdata[%0d]: got %h expected deadbeef", i, resp_rdata[0]); end
         n_checks++; if (req_ready[0] !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready[%0d]: got %b expected 0", i, req_ready[0]); end
         @(negedge clock);
      end
      resp_ready = 1'b1;
      @(negedge clock);
      n_checks++; if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin n_fail++; $display("FAIL bp_release: got valid %b ready %b expected 0/1", resp_valid[0], req_ready[0]); end
   endtask

   task automatic test_reset_in_wait();
      int lat; logic [31:0] rd; logic er; logic seen;
      req_rw = 1'b1; req_addr = 8'h20; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
      resp_ready = 1'b1;
      req_valid[3] = 1'b1;
      @(negedge clock);
      req_valid[3] = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (resp_valid[3]) seen = 1'b1;
         @(negedge clock);
      end
      n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_wait_no_resp: got %b expected 0", seen); end
      n_checks++; if (req_ready[3] !== 1'b1) begin n_fail++; $display("FAIL rst_wait_idle: got %b expected 1", req_ready[3]); end
      access(3, 1'b0, 8'h20, 32'h0, 4'h0, lat, rd, er);
      n_checks++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rst_wait_committed: got %h expected cafef00d", rd); end
   endtask

   task automatic test_latency_sweep();
      int lat; logic [31:0] rd; logic er;
      access(2, 1'b1, 8'h05, 32'h0BADCAFE, 4'hF, lat, rd, er);
      n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL lat1_wr: got %0d expected 1", lat); end
      access(2, 1'b0, 8'h05, 32'h0, 4'h0, lat, rd, er);
      n_checks++; if (lat !== 1 || rd !== 32'h0BADCAFE) begin n_fail++; $display("FAIL lat1_rd: got lat %0d data %h expected 1/0badcafe", lat, rd); end
      access(3, 1'b1, 8'h07, 32'h13579BDF, 4'hF, lat, rd, er);
      n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL lat4_wr: got %0d expected 4", lat); end
      access(3, 1'b0, 8'h07, 32'h0, 4'h0, lat, rd, er);
      n_checks++; if (lat !== 4 || rd !== 32'h13579BDF) begin n_fail++; $display("FAIL lat4_rd: got lat %0d data %h expected 4/13579bdf", lat, rd); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_byte_enable();
      test_out_of_range();
      test_back_pressure();
      test_reset_in_wait();
      test_latency_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
